// File: rtl/feature_load_scheduler.sv
// -----------------------------------------------------------------------------
// feature_load_scheduler
//
// Sequences one convolution tile through feature_buffer. On start it pulses
// calculate_begin, then fetches the tile's feature words from memory in
// bursts. Each returned word goes to the patch-1 or patch-2 buffer write port
// under that buffer's ready signal. When every burst has been consumed it
// waits for calculate_finish and then pulses done.
//
// Parameters:
//   MEM_DATA_WIDTH  width of one memory word (bits)
//   MEM_ADDR_WIDTH  byte address width
//   BURST_LEN       maximum beats per read burst (1..255)
//
// Ports:
//   system_clk, rst            clock, asynchronous active-high reset
//   start / done / busy        tile control from/to the layer controller
//   row_size, col_size,
//   double_patch,
//   base_addr_1, base_addr_2   tile description, sampled on start
//   mem_rd_*                   memory read port (request + data stream)
//   feature_data,
//   feature_buffer_N_valid/_ready  write ports of the two patch buffers
//   calculate_begin / _finish  compute handshake with feature_buffer
//   perf_stall_cycles          stall counter (see macro below)
//
// Optional feature macro: FEATURE_LOAD_PERF_EN
//   Defined:   perf_stall_cycles counts DATA cycles where a beat is offered but
//              the selected buffer is not ready (cleared at BEGIN, saturating).
//   Undefined: perf_stall_cycles is tied to 0.
// -----------------------------------------------------------------------------
module feature_load_scheduler #(
    parameter int MEM_DATA_WIDTH = 512,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int BURST_LEN      = 16
) (
    input  logic                      system_clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      done,
    output logic                      busy,
    input  logic [9:0]                row_size,
    input  logic [9:0]                col_size,
    input  logic                      double_patch,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr_1,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr_2,
    output logic                      mem_rd_req,
    output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [7:0]                mem_rd_len,
    input  logic                      mem_rd_ack,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
    input  logic                      mem_rd_data_valid,
    output logic                      mem_rd_data_ready,
    output logic [MEM_DATA_WIDTH-1:0] feature_data,
    output logic                      feature_buffer_1_valid,
    output logic                      feature_buffer_2_valid,
    input  logic                      feature_buffer_1_ready,
    input  logic                      feature_buffer_2_ready,
    output logic                      calculate_begin,
    input  logic                      calculate_finish,
    output logic [31:0]               perf_stall_cycles
);

    localparam int WORD_BYTES = MEM_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEGIN,
        S_REQ,
        S_DATA,
        S_WAIT_FIN
    } state_t;

    state_t                    state_q;
    logic                      done_q;
    logic                      double_q;
    logic                      cur_patch_q;   // 0 = patch 1, 1 = patch 2
    logic [17:0]               word_off_q;
    logic [17:0]               remaining_q;
    logic [7:0]                beat_q;
    logic [MEM_ADDR_WIDTH-1:0] base1_q;
    logic [MEM_ADDR_WIDTH-1:0] base2_q;

    logic [17:0]               total_words_d;
    logic [7:0]                burst_len_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_d;
    logic                      sel_ready;
    logic                      in_data;
    logic                      beat_acc;
    logic                      last_beat;

    // Four pixels per memory word, rounded up.
    assign total_words_d = 18'((20'(row_size) * 20'(col_size) + 20'd3) >> 2);

    always_comb begin
        burst_len_d = 8'(BURST_LEN);
        if (remaining_q < 18'(BURST_LEN)) begin
            burst_len_d = remaining_q[7:0];
        end
    end

    // Both patches share the word offset; only the base differs. The address
    // arithmetic is deliberately truncated so it wraps at the address width.
    assign addr_d = (cur_patch_q ? base2_q : base1_q)
                  + MEM_ADDR_WIDTH'(word_off_q) * MEM_ADDR_WIDTH'(WORD_BYTES);

    assign sel_ready = cur_patch_q ? feature_buffer_2_ready : feature_buffer_1_ready;
    assign in_data   = (state_q == S_DATA);
    assign beat_acc  = in_data && mem_rd_data_valid && sel_ready;
    assign last_beat = beat_acc && (beat_q == burst_len_d - 8'd1);

    // Outputs are decoded from registered state only, so an asynchronous
    // reset clears all of them in the same cycle.
    assign busy                   = (state_q != S_IDLE);
    assign done                   = done_q;
    assign calculate_begin        = (state_q == S_BEGIN);
    assign mem_rd_req             = (state_q == S_REQ);
    assign mem_rd_addr            = mem_rd_req ? addr_d : '0;
    assign mem_rd_len             = mem_rd_req ? burst_len_d : '0;
    assign mem_rd_data_ready      = in_data && sel_ready;
    assign feature_data           = in_data ? mem_rd_data : '0;
    assign feature_buffer_1_valid = beat_acc && !cur_patch_q;
    assign feature_buffer_2_valid = beat_acc && cur_patch_q;

    // Base addresses are pure data and need no reset.
    always_ff @(posedge system_clk) begin
        if (state_q == S_IDLE && start) begin
            base1_q <= base_addr_1;
            base2_q <= base_addr_2;
        end
    end

    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            double_q    <= 1'b0;
            cur_patch_q <= 1'b0;
            word_off_q  <= '0;
            remaining_q <= '0;
            beat_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        double_q    <= double_patch;
                        cur_patch_q <= 1'b0;
                        word_off_q  <= '0;
                        remaining_q <= total_words_d;
                        beat_q      <= '0;
                        // An empty tile finishes immediately without touching
                        // memory or feature_buffer.
                        if (total_words_d == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_BEGIN;
                        end
                    end
                end
                S_BEGIN: begin
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (mem_rd_ack) begin
                        beat_q  <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (last_beat) begin
                        beat_q <= '0;
                        if (double_q && !cur_patch_q) begin
                            // Same words again from the patch-2 base.
                            cur_patch_q <= 1'b1;
                            state_q     <= S_REQ;
                        end else begin
                            cur_patch_q <= 1'b0;
                            word_off_q  <= word_off_q + 18'(burst_len_d);
                            remaining_q <= remaining_q - 18'(burst_len_d);
                            if (remaining_q == 18'(burst_len_d)) begin
                                state_q <= S_WAIT_FIN;
                            end else begin
                                state_q <= S_REQ;
                            end
                        end
                    end else if (beat_acc) begin
                        beat_q <= beat_q + 8'd1;
                    end
                end
                S_WAIT_FIN: begin
                    if (calculate_finish) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FEATURE_LOAD_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (state_q == S_BEGIN) begin
            perf_q <= '0;
        end else if (in_data && mem_rd_data_valid && !sel_ready && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_feature_load_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for feature_load_scheduler: table of tile descriptions with
// expected request sequences, plus hand-written sequences for reset, empty
// tiles and mid-burst reset. Uses 32-byte memory words (MEM_DATA_WIDTH=256)
// so a 16-word offset is 0x200 bytes.
// -----------------------------------------------------------------------------
module tb_feature_load_scheduler;

    localparam int DW = 256;
    localparam int AW = 32;

`ifdef FEATURE_LOAD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic          system_clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          done;
    logic          busy;
    logic [9:0]    row_size = '0;
    logic [9:0]    col_size = '0;
    logic          double_patch = 1'b0;
    logic [AW-1:0] base_addr_1 = '0;
    logic [AW-1:0] base_addr_2 = '0;
    logic          mem_rd_req;
    logic [AW-1:0] mem_rd_addr;
    logic [7:0]    mem_rd_len;
    logic          mem_rd_ack = 1'b0;
    logic [DW-1:0] mem_rd_data = '0;
    logic          mem_rd_data_valid = 1'b0;
    logic          mem_rd_data_ready;
    logic [DW-1:0] feature_data;
    logic          feature_buffer_1_valid;
    logic          feature_buffer_2_valid;
    logic          feature_buffer_1_ready = 1'b1;
    logic          feature_buffer_2_ready = 1'b1;
    logic          calculate_begin;
    logic          calculate_finish = 1'b0;
    logic [31:0]   perf_stall_cycles;

    feature_load_scheduler #(
        .MEM_DATA_WIDTH(DW),
        .MEM_ADDR_WIDTH(AW),
        .BURST_LEN     (16)
    ) dut (
        .system_clk            (system_clk),
        .rst                   (rst),
        .start                 (start),
        .done                  (done),
        .busy                  (busy),
        .row_size              (row_size),
        .col_size              (col_size),
        .double_patch          (double_patch),
        .base_addr_1           (base_addr_1),
        .base_addr_2           (base_addr_2),
        .mem_rd_req            (mem_rd_req),
        .mem_rd_addr           (mem_rd_addr),
        .mem_rd_len            (mem_rd_len),
        .mem_rd_ack            (mem_rd_ack),
        .mem_rd_data           (mem_rd_data),
        .mem_rd_data_valid     (mem_rd_data_valid),
        .mem_rd_data_ready     (mem_rd_data_ready),
        .feature_data          (feature_data),
        .feature_buffer_1_valid(feature_buffer_1_valid),
        .feature_buffer_2_valid(feature_buffer_2_valid),
        .feature_buffer_1_ready(feature_buffer_1_ready),
        .feature_buffer_2_ready(feature_buffer_2_ready),
        .calculate_begin       (calculate_begin),
        .calculate_finish      (calculate_finish),
        .perf_stall_cycles     (perf_stall_cycles)
    );

    always #5 system_clk = ~system_clk;

    logic any_out;
    assign any_out = done | busy | mem_rd_req | (|mem_rd_addr) | (|mem_rd_len)
                   | mem_rd_data_ready | (|feature_data) | feature_buffer_1_valid
                   | feature_buffer_2_valid | calculate_begin | (|perf_stall_cycles);

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]       r;
        logic [9:0]       c;
        logic             dp;
        logic [31:0]      b1;
        logic [31:0]      b2;
        int               stall_at;
        int               stall_len;
        bit               toggle;
        bit               poke;
        int               perf;       // -1: use the bench's own stall count
        int               nreq;
        logic [5:0][31:0] a;
        logic [5:0][7:0]  l;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    task automatic set_vec(input int i, input logic [9:0] r, input logic [9:0] c,
                           input logic dp, input logic [31:0] b1, input logic [31:0] b2,
                           input int sa, input int sl, input bit tg, input bit pk,
                           input int perf);
        vecs[i].r = r;  vecs[i].c = c;  vecs[i].dp = dp;
        vecs[i].b1 = b1; vecs[i].b2 = b2;
        vecs[i].stall_at = sa; vecs[i].stall_len = sl;
        vecs[i].toggle = tg; vecs[i].poke = pk;
        vecs[i].perf = perf; vecs[i].nreq = 0;
        vecs[i].a = '0; vecs[i].l = '0;
    endtask

    task automatic add_req(input int i, input logic [31:0] a, input logic [7:0] l);
        vecs[i].a[vecs[i].nreq] = a;
        vecs[i].l[vecs[i].nreq] = l;
        vecs[i].nreq++;
    endtask

    // Measurements of the most recent tile.
    int          m_begin, m_begin_at, m_nreq, m_w1, m_w2, m_done, m_done_at;
    int          m_fin_at, m_stalls, m_bad, m_hold_bad, m_timeout;
    logic        m_busy_done;
    logic        m_rst_any;
    logic [31:0] m_addr[6];
    logic [7:0]  m_len[6];
    logic [31:0] m_perf;

    // Runs one tile: acts as memory and as both feature buffers, counts writes
    // and checks each accepted beat lands on the expected patch with the
    // expected data. abort_at >= 0 asserts rst once that many beats are in.
    task automatic run_tile(input logic [9:0] r, input logic [9:0] c, input logic dp,
                            input logic [31:0] b1, input logic [31:0] b2,
                            input int stall_at, input int stall_len,
                            input bit toggle, input bit poke, input int abort_at);
        int          exp_beats, accepted, beats_left, stall_left, wait_cnt, req_age, cur_patch;
        bit          poked_data, fin_early, finished, aborted;
        logic [31:0] seed;
        logic [DW-1:0] word;
        logic        v1, v2, exp_rdy;
        m_begin = 0; m_begin_at = -1; m_nreq = 0; m_w1 = 0; m_w2 = 0;
        m_done = 0; m_done_at = -1; m_fin_at = -1; m_stalls = 0; m_bad = 0;
        m_hold_bad = 0; m_timeout = 0; m_busy_done = 1'b1; m_rst_any = 1'b1; m_perf = '0;
        exp_beats  = ((int'(r) * int'(c) + 3) / 4) * (dp ? 2 : 1);
        accepted = 0; beats_left = 0; stall_left = stall_len; wait_cnt = 0;
        req_age = 0; cur_patch = 1; poked_data = 0; fin_early = 0;
        finished = 0; aborted = 0;
        seed = 32'h5A00_0000;
        word = {8{seed}};
        @(negedge system_clk);
        row_size = r; col_size = c; double_patch = dp;
        base_addr_1 = b1; base_addr_2 = b2; start = 1'b1;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge system_clk);
            start = 1'b0; mem_rd_ack = 1'b0; mem_rd_data_valid = 1'b0;
            calculate_finish = 1'b0;
            feature_buffer_1_ready = 1'b1; feature_buffer_2_ready = 1'b1;
            if (calculate_begin) begin
                m_begin++;
                if (m_begin_at < 0) m_begin_at = cyc;
            end
            if (done) begin
                m_done++;
                if (m_done_at < 0) begin
                    m_done_at   = cyc;
                    m_busy_done = busy;
                end
            end
            if (m_done_at >= 0 && cyc >= m_done_at + 3) begin
                m_perf   = perf_stall_cycles;
                finished = 1;
                break;
            end
            if (mem_rd_req) begin
                req_age++;
                if (req_age == 1) begin
                    if (m_nreq < 6) begin
                        m_addr[m_nreq] = mem_rd_addr;
                        m_len[m_nreq]  = mem_rd_len;
                    end
                    m_nreq++;
                    cur_patch = (dp && (m_nreq % 2 == 0)) ? 2 : 1;
                end else if (m_nreq <= 6) begin
                    if (mem_rd_addr !== m_addr[m_nreq-1] || mem_rd_len !== m_len[m_nreq-1]) m_bad++;
                end
                if (!toggle || req_age >= 3) begin
                    mem_rd_ack = 1'b1;
                    beats_left = int'(mem_rd_len);
                    req_age    = 0;
                end
            end else begin
                if (toggle) mem_rd_ack = cyc[2];
                if (beats_left > 0) begin
                    mem_rd_data_valid = toggle ? cyc[0] : 1'b1;
                    mem_rd_data = word;
                    if (toggle) begin
                        feature_buffer_1_ready = cyc[1];
                        feature_buffer_2_ready = cyc[1];
                    end
                    if (stall_at >= 0 && accepted == stall_at && stall_left > 0) begin
                        feature_buffer_1_ready = 1'b0;
                        stall_left--;
                    end
                    if (poke && accepted == 3 && !poked_data) begin
                        start = 1'b1;
                        poked_data = 1;
                    end
                    if (poke && accepted == 5 && !fin_early) begin
                        calculate_finish = 1'b1;
                        fin_early = 1;
                    end
                end
            end
            if (exp_beats > 0 && accepted == exp_beats) begin
                wait_cnt++;
                if (poke && wait_cnt == 2) start = 1'b1;
                if (wait_cnt == 4) begin
                    calculate_finish = 1'b1;
                    m_fin_at = cyc;
                end
            end
            if (abort_at >= 0 && accepted == abort_at) begin
                rst = 1'b1;
                #1;
                m_rst_any = any_out;
                aborted = 1;
                break;
            end
            #1;
            v1 = feature_buffer_1_valid;
            v2 = feature_buffer_2_valid;
            exp_rdy = (cur_patch == 1) ? feature_buffer_1_ready : feature_buffer_2_ready;
            if (v1 && v2) m_bad++;
            if (v1) m_w1++;
            if (v2) m_w2++;
            if (mem_rd_data_valid && mem_rd_data_ready !== exp_rdy) m_bad++;
            if (mem_rd_data_valid && mem_rd_data_ready) begin
                if (feature_data !== word) m_bad++;
                if ((cur_patch == 1 && !v1) || (cur_patch == 2 && !v2)) m_bad++;
                accepted++;
                beats_left--;
                seed = seed + 32'd1;
                word = {8{seed}};
            end else begin
                if (mem_rd_data_valid) m_stalls++;
                if (v1 || v2) m_hold_bad++;
            end
        end
        if (!finished && !aborted) m_timeout = 1;
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int tw, exp_perf;
        bit saw_begin, saw_req, saw_busy;
        int done_cnt;

        set_vec(0, 10'd8,  10'd8,  1'b0, 32'h0000_1000, 32'h0000_8000, -1, 0, 1'b0, 1'b0, 0);
        add_req(0, 32'h0000_1000, 8'd16);
        set_vec(1, 10'd10, 10'd10, 1'b1, 32'h0000_1000, 32'h0000_8000, -1, 0, 1'b0, 1'b0, 0);
        add_req(1, 32'h0000_1000, 8'd16);
        add_req(1, 32'h0000_8000, 8'd16);
        add_req(1, 32'h0000_1200, 8'd9);
        add_req(1, 32'h0000_8200, 8'd9);
        set_vec(2, 10'd8,  10'd8,  1'b0, 32'h0000_1000, 32'h0000_8000, 8, 5, 1'b0, 1'b0, 5);
        add_req(2, 32'h0000_1000, 8'd16);
        set_vec(3, 10'd10, 10'd10, 1'b0, 32'hFFFF_FF00, 32'h0000_8000, -1, 0, 1'b1, 1'b0, -1);
        add_req(3, 32'hFFFF_FF00, 8'd16);
        add_req(3, 32'h0000_0100, 8'd9);
        set_vec(4, 10'd6,  10'd7,  1'b1, 32'h0000_2000, 32'h0000_3000, -1, 0, 1'b0, 1'b1, 0);
        add_req(4, 32'h0000_2000, 8'd11);
        add_req(4, 32'h0000_3000, 8'd11);
        set_vec(5, 10'd1,  10'd1,  1'b0, 32'h0000_0040, 32'h0000_8000, -1, 0, 1'b0, 1'b0, 0);
        add_req(5, 32'h0000_0040, 8'd1);
        set_vec(6, 10'd20, 10'd13, 1'b0, 32'h0000_0000, 32'h0000_8000, -1, 0, 1'b0, 1'b0, 0);
        add_req(6, 32'h0000_0000, 8'd16);
        add_req(6, 32'h0000_0200, 8'd16);
        add_req(6, 32'h0000_0400, 8'd16);
        add_req(6, 32'h0000_0600, 8'd16);
        add_req(6, 32'h0000_0800, 8'd1);

        // Reset state.
        repeat (3) @(negedge system_clk);
        check("reset_outputs_zero", any_out, 1'b0);
        rst = 1'b0;
        @(negedge system_clk);
        check("idle_after_reset_busy", busy, 1'b0);

        for (int i = 0; i < NV; i++) begin
            run_tile(vecs[i].r, vecs[i].c, vecs[i].dp, vecs[i].b1, vecs[i].b2,
                     vecs[i].stall_at, vecs[i].stall_len, vecs[i].toggle, vecs[i].poke, -1);
            tw = (int'(vecs[i].r) * int'(vecs[i].c) + 3) / 4;
            check($sformatf("v%0d timeout", i), m_timeout, 0);
            check($sformatf("v%0d begin_count", i), m_begin, 1);
            check($sformatf("v%0d begin_cycle", i), m_begin_at, 1);
            check($sformatf("v%0d req_count", i), m_nreq, vecs[i].nreq);
            for (int k = 0; k < vecs[i].nreq && k < m_nreq && k < 6; k++) begin
                check($sformatf("v%0d req%0d_addr", i, k), m_addr[k], vecs[i].a[k]);
                check($sformatf("v%0d req%0d_len", i, k), m_len[k], vecs[i].l[k]);
            end
            check($sformatf("v%0d patch1_writes", i), m_w1, tw);
            check($sformatf("v%0d patch2_writes", i), m_w2, vecs[i].dp ? tw : 0);
            check($sformatf("v%0d beat_errors", i), m_bad, 0);
            check($sformatf("v%0d write_while_stalled", i), m_hold_bad, 0);
            check($sformatf("v%0d done_count", i), m_done, 1);
            check($sformatf("v%0d done_after_finish", i), m_done_at, m_fin_at + 1);
            check($sformatf("v%0d busy_at_done", i), m_busy_done, 1'b0);
            if (vecs[i].perf >= 0)
                check($sformatf("v%0d stall_cycles_seen", i), m_stalls, vecs[i].perf);
            exp_perf = vecs[i].perf < 0 ? m_stalls : vecs[i].perf;
            check($sformatf("v%0d perf_stall_cycles", i), m_perf, PERF_ON ? exp_perf : 0);
        end

        // Empty tile: done next cycle, nothing else.
        @(negedge system_clk);
        row_size = 10'd0; col_size = 10'd5; double_patch = 1'b0; start = 1'b1;
        saw_begin = 0; saw_req = 0; saw_busy = 0; done_cnt = 0;
        @(negedge system_clk);
        start = 1'b0;
        check("empty_done_next_cycle", done, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (done) done_cnt++;
            if (calculate_begin) saw_begin = 1;
            if (mem_rd_req) saw_req = 1;
            if (busy) saw_busy = 1;
            @(negedge system_clk);
        end
        check("empty_done_count", done_cnt, 1);
        check("empty_no_begin", saw_begin, 1'b0);
        check("empty_no_request", saw_req, 1'b0);
        check("empty_never_busy", saw_busy, 1'b0);

        // Reset after 7 beats of a 16-beat burst, then replay the tile.
        run_tile(10'd8, 10'd8, 1'b0, 32'h0000_1000, 32'h0000_8000, -1, 0, 1'b0, 1'b0, 7);
        check("abort_outputs_zero", m_rst_any, 1'b0);
        check("abort_req_count", m_nreq, 1);
        @(negedge system_clk);
        rst = 1'b0;
        run_tile(10'd8, 10'd8, 1'b0, 32'h0000_1000, 32'h0000_8000, -1, 0, 1'b0, 1'b0, -1);
        check("replay_timeout", m_timeout, 0);
        check("replay_req_count", m_nreq, 1);
        check("replay_addr", m_addr[0], 32'h0000_1000);
        check("replay_len", m_len[0], 8'd16);
        check("replay_patch1_writes", m_w1, 16);
        check("replay_beat_errors", m_bad, 0);
        check("replay_done_count", m_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
